flex_pts_stream_tx: RTL and testbench

Parametrised, streaming parallel-to-serial transmitter that succeeds the single-word PTS shift register on the USB TX path. It accepts words through a valid/ready handshake into a one-deep holding register, shifts each word out one bit per `shift_strobe` tick (the bit-period enable from the TX timer), and chains consecutive words without a gap. It marks word and packet boundaries, and it flags underruns, so the encoder downstream can frame EOP.

---
 rtl/flex_pts_stream_tx.sv | 174 +++++++++++++++++
 tb/tb_flex_pts_stream_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/flex_pts_stream_tx.sv
// flex_pts_stream_tx
//    Streaming parallel-to-serial transmitter for the USB TX path. Words
//    enter a one-deep holding register through a valid/ready handshake.
//    Each word is shifted out one bit per shift_strobe tick. A non-last word
//    chains gaplessly into the next held word. Word and packet ends, and
//    underruns, are reported as registered one-cycle pulses.
//
//    state    | meaning
//    ---------+---------------------------------------------------------
//    ST_IDLE  | serial_out = IDLE_VAL; loads the held word when present
//    ST_SHIFT | driving the current word, one bit per shift_strobe
//
// Ports
//    clk          in   system clock, rising edge
//    rst          in   synchronous active-high reset
//    shift_strobe in   one-cycle bit-period tick
//    data_in      in   word to transmit (NUM_BITS)
//    last_in      in   data_in is the final word of a packet
//    data_valid   in   producer offers data_in/last_in
//    data_ready   out  holding register empty
//    serial_out   out  current bit, IDLE_VAL when not shifting
//    busy         out  shifter in ST_SHIFT
//    word_done    out  pulse: last bit of a word consumed
//    eop_done     out  pulse: last bit of a last_in word consumed
//    underrun     out  pulse: non-last word ended with nothing held
module flex_pts_stream_tx #(
   parameter int unsigned NUM_BITS  = 8,
   parameter logic        SHIFT_MSB = 1'b0,
   parameter logic        IDLE_VAL  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                shift_strobe,
   input  logic [NUM_BITS-1:0] data_in,
   input  logic                last_in,
   input  logic                data_valid,
   output logic                data_ready,
   output logic                serial_out,
   output logic                busy,
   output logic                word_done,
   output logic                eop_done,
   output logic                underrun
);

   localparam int unsigned     CNT_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_BITS-1:0] hold_data_q, hold_data_d;
   logic                hold_last_q, hold_last_d;
   logic                hold_valid_q, hold_valid_d;
   logic [NUM_BITS-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                cur_last_q, cur_last_d;
   logic                word_done_q, word_done_d;
   logic                eop_done_q, eop_done_d;
   logic                underrun_q, underrun_d;

   logic                final_strobe;

   assign final_strobe = (state_q == ST_SHIFT) && shift_strobe && (cnt_q == CNT_LAST);

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         hold_data_q  <= '0;
         hold_last_q  <= 1'b0;
         hold_valid_q <= 1'b0;
         sr_q         <= '0;
         cnt_q        <= '0;
         cur_last_q   <= 1'b0;
         word_done_q  <= 1'b0;
         eop_done_q   <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_data_q  <= hold_data_d;
         hold_last_q  <= hold_last_d;
         hold_valid_q <= hold_valid_d;
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         cur_last_q   <= cur_last_d;
         word_done_q  <= word_done_d;
         eop_done_q   <= eop_done_d;
         underrun_q   <= underrun_d;
      end
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (hold_valid_q) state_d = ST_SHIFT;
         ST_SHIFT: begin
            // a last word always drops to idle, even with a word waiting
            if (final_strobe && (cur_last_q || !hold_valid_q)) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // datapath and registered pulses
   always_comb begin
      hold_data_d  = hold_data_q;
      hold_last_d  = hold_last_q;
      hold_valid_d = hold_valid_q;
      sr_d         = sr_q;
      cnt_d        = cnt_q;
      cur_last_d   = cur_last_q;
      word_done_d  = 1'b0;
      eop_done_d   = 1'b0;
      underrun_d   = 1'b0;

      // accept only into an empty holder, so accept and release never coincide
      if (data_valid && !hold_valid_q) begin
         hold_data_d  = data_in;
         hold_last_d  = last_in;
         hold_valid_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (hold_valid_q) begin
               sr_d         = hold_data_q;
               cur_last_d   = hold_last_q;
               cnt_d        = '0;
               hold_valid_d = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (shift_strobe) begin
               if (cnt_q != CNT_LAST) begin
                  if (SHIFT_MSB) sr_d = {sr_q[NUM_BITS-2:0], IDLE_VAL};
                  else           sr_d = {IDLE_VAL, sr_q[NUM_BITS-1:1]};
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  word_done_d = 1'b1;
                  if (cur_last_q) begin
                     eop_done_d = 1'b1;
                  end else if (hold_valid_q) begin
                     // gapless chain into the held word
                     sr_d         = hold_data_q;
                     cur_last_d   = hold_last_q;
                     cnt_d        = '0;
                     hold_valid_d = 1'b0;
                  end else begin
                     underrun_d = 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // outputs
   always_comb begin
      data_ready = !hold_valid_q;
      busy       = (state_q == ST_SHIFT);
      serial_out = IDLE_VAL;
      if (state_q == ST_SHIFT) serial_out = SHIFT_MSB ? sr_q[NUM_BITS-1] : sr_q[0];
   end

   assign word_done = word_done_q;
   assign eop_done  = eop_done_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_flex_pts_stream_tx.sv
module tb_flex_pts_stream_tx;

   logic       clk;
   logic       rst;
   logic       shift_strobe;
   logic [7:0] data_in;
   logic       last_in;
   logic       data_valid;
   logic       data_ready, serial_out, busy, word_done, eop_done, underrun;

   logic       m_strobe;
   logic [3:0] m_data;
   logic       m_last, m_valid;
   logic       m_ready, m_serial, m_busy, m_wd, m_eop, m_ur;

   int n_cmp = 0;
   int n_err = 0;

   flex_pts_stream_tx #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .IDLE_VAL(1'b1)) u_dut (
      .clk(clk), .rst(rst), .shift_strobe(shift_strobe), .data_in(data_in),
      .last_in(last_in), .data_valid(data_valid), .data_ready(data_ready),
      .serial_out(serial_out), .busy(busy), .word_done(word_done),
      .eop_done(eop_done), .underrun(underrun)
   );

   flex_pts_stream_tx #(.NUM_BITS(4), .SHIFT_MSB(1'b1), .IDLE_VAL(1'b1)) u_msb (
      .clk(clk), .rst(rst), .shift_strobe(m_strobe), .data_in(m_data),
      .last_in(m_last), .data_valid(m_valid), .data_ready(m_ready),
      .serial_out(m_serial), .busy(m_busy), .word_done(m_wd),
      .eop_done(m_eop), .underrun(m_ur)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic [7:0] exp_seq;   // bit i = i-th bit expected on the wire
      logic       exp_eop;
      logic       exp_ur;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_word(input logic [7:0] d, input logic l);
      data_in    = d;
      last_in    = l;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      chk("hold_full", {7'd0, data_ready}, 8'd0);
   endtask

   // Checks all 8 bits of the word in flight; returns right after the
   // edge that consumes the final strobe.
   task automatic shift_word(input logic [7:0] exp_seq, input int gap, input string tag);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_bit%0d", tag, i), {7'd0, serial_out}, {7'd0, exp_seq[i]});
         for (int g = 1; g < gap; g++) begin
            tick();
            chk($sformatf("%s_hold%0d", tag, i), {7'd0, serial_out}, {7'd0, exp_seq[i]});
         end
         shift_strobe = 1'b1;
         tick();
         shift_strobe = 1'b0;
         if (i < 7) begin
            chk($sformatf("%s_wd_early%0d", tag, i), {7'd0, word_done}, 8'd0);
            chk($sformatf("%s_busy%0d", tag, i), {7'd0, busy}, 8'd1);
         end
      end
   endtask

   initial begin
      logic [3:0] m_exp;

      // LSB first: wire order equals bit order of the word
      vecs[0] = '{data: 8'hA5, last: 1'b1, exp_seq: 8'hA5, exp_eop: 1'b1, exp_ur: 1'b0};
      vecs[1] = '{data: 8'hFF, last: 1'b0, exp_seq: 8'hFF, exp_eop: 1'b0, exp_ur: 1'b1};
      vecs[2] = '{data: 8'h3C, last: 1'b1, exp_seq: 8'h3C, exp_eop: 1'b1, exp_ur: 1'b0};
      vecs[3] = '{data: 8'h01, last: 1'b0, exp_seq: 8'h01, exp_eop: 1'b0, exp_ur: 1'b1};

      rst = 1'b1; shift_strobe = 1'b0; data_in = 8'h00; last_in = 1'b0; data_valid = 1'b0;
      m_strobe = 1'b0; m_data = 4'h0; m_last = 1'b0; m_valid = 1'b0;

      // reset then idle
      tick();
      tick();
      rst = 1'b0;
      chk("rst_serial", {7'd0, serial_out}, 8'd1);
      chk("rst_ready",  {7'd0, data_ready}, 8'd1);
      chk("rst_busy",   {7'd0, busy},       8'd0);
      chk("rst_pulses", {5'd0, word_done, eop_done, underrun}, 8'd0);
      chk("rst_m_serial", {7'd0, m_serial}, 8'd1);
      for (int i = 0; i < 3; i++) begin
         shift_strobe = 1'b1;
         tick();
         shift_strobe = 1'b0;
         tick();
         chk("idle_strobe_serial", {7'd0, serial_out}, 8'd1);
         chk("idle_strobe_busy",   {7'd0, busy},       8'd0);
      end

      // single words, strobe every 4 clocks
      for (int v = 0; v < 4; v++) begin
         send_word(vecs[v].data, vecs[v].last);
         chk("pre_load_busy", {7'd0, busy}, 8'd0);
         tick();
         chk("load_busy",  {7'd0, busy},       8'd1);
         chk("load_ready", {7'd0, data_ready}, 8'd1);
         shift_word(vecs[v].exp_seq, 4, $sformatf("vec%0d", v));
         chk("vec_wd",     {7'd0, word_done},  8'd1);
         chk("vec_eop",    {7'd0, eop_done},   {7'd0, vecs[v].exp_eop});
         chk("vec_ur",     {7'd0, underrun},   {7'd0, vecs[v].exp_ur});
         chk("vec_end_busy",   {7'd0, busy},       8'd0);
         chk("vec_end_serial", {7'd0, serial_out}, 8'd1);
         tick();
         chk("vec_pulse_len", {5'd0, word_done, eop_done, underrun}, 8'd0);
      end

      // last word followed by a waiting word: not chained, one idle clock
      send_word(8'h3C, 1'b1);
      tick();
      send_word(8'h80, 1'b1);
      shift_word(8'h3C, 2, "gap_a");
      chk("gap_eop",    {7'd0, eop_done},   8'd1);
      chk("gap_busy",   {7'd0, busy},       8'd0);
      chk("gap_serial", {7'd0, serial_out}, 8'd1);
      chk("gap_ready",  {7'd0, data_ready}, 8'd0);
      tick();
      chk("gap_reload_busy", {7'd0, busy}, 8'd1);
      shift_word(8'h80, 2, "gap_b");
      chk("gap_b_eop", {7'd0, eop_done}, 8'd1);
      tick();

      // gapless chaining, strobe every 3 clocks
      data_in = 8'h01; last_in = 1'b0; data_valid = 1'b1;
      tick();
      data_in = 8'h80; last_in = 1'b1;
      tick();
      chk("chain_ready_after_load", {7'd0, data_ready}, 8'd1);
      chk("chain_busy_load",        {7'd0, busy},       8'd1);
      tick();
      data_valid = 1'b0;
      chk("chain_hold_full", {7'd0, data_ready}, 8'd0);
      shift_word(8'h01, 3, "chain_a");
      chk("chain_wd1",     {7'd0, word_done},  8'd1);
      chk("chain_eop1",    {7'd0, eop_done},   8'd0);
      chk("chain_ur1",     {7'd0, underrun},   8'd0);
      chk("chain_busy1",   {7'd0, busy},       8'd1);
      chk("chain_ready1",  {7'd0, data_ready}, 8'd1);
      shift_word(8'h80, 3, "chain_b");
      chk("chain_wd2",   {7'd0, word_done}, 8'd1);
      chk("chain_eop2",  {7'd0, eop_done},  8'd1);
      chk("chain_ur2",   {7'd0, underrun},  8'd0);
      chk("chain_busy2", {7'd0, busy},      8'd0);
      tick();

      // mid-word reset with a word also held
      send_word(8'hFF, 1'b0);
      tick();
      send_word(8'h55, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         shift_strobe = 1'b1;
         tick();
         shift_strobe = 1'b0;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_serial", {7'd0, serial_out}, 8'd1);
      chk("mrst_busy",   {7'd0, busy},       8'd0);
      chk("mrst_ready",  {7'd0, data_ready}, 8'd1);
      chk("mrst_pulses", {5'd0, word_done, eop_done, underrun}, 8'd0);
      for (int i = 0; i < 4; i++) begin
         shift_strobe = i[0];
         tick();
         chk("mrst_no_reload", {7'd0, busy}, 8'd0);
         chk("mrst_quiet", {5'd0, word_done, eop_done, underrun}, 8'd0);
      end
      shift_strobe = 1'b0;

      // MSB-first, 4-bit build: 1100 goes out as 1,1,0,0
      m_exp   = 4'b0011;
      m_data  = 4'b1100;
      m_last  = 1'b1;
      m_valid = 1'b1;
      tick();
      m_valid = 1'b0;
      tick();
      chk("msb_busy", {7'd0, m_busy}, 8'd1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("msb_bit%0d", i), {7'd0, m_serial}, {7'd0, m_exp[i]});
         tick();
         m_strobe = 1'b1;
         tick();
         m_strobe = 1'b0;
      end
      chk("msb_wd",     {7'd0, m_wd},     8'd1);
      chk("msb_eop",    {7'd0, m_eop},    8'd1);
      chk("msb_ur",     {7'd0, m_ur},     8'd0);
      chk("msb_idle",   {7'd0, m_serial}, 8'd1);
      chk("msb_busy_end", {7'd0, m_busy}, 8'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
